// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_pkg                                                   |
// | Description : Shared types and constants for the UART TX frame feeder.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [1:0] {
    s_FR_IDLE      = 2'd0,
    s_FR_ISSUE     = 2'd1,
    s_FR_WAIT_ACK  = 2'd2,
    s_FR_WAIT_DONE = 2'd3
  } fr_state_e;

  localparam logic [7:0] c_SYNC_BYTE_DEFAULT = 8'hAA;
  localparam int         c_CKSUM_W           = 8;

  // Modulo-256 accumulate; the carry out of bit 7 is dropped by the width.
  function automatic logic [c_CKSUM_W-1:0] cksum_add(
    input logic [c_CKSUM_W-1:0] acc,
    input logic [7:0]           b
  );
    return acc + b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_byte_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : frame_byte_mux                                             |
// | Description : Selects the wire byte for a frame position from the        |
// |               latched ID, payload and running checksum.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module frame_byte_mux
  import uart_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE     = c_SYNC_BYTE_DEFAULT,
  parameter int         IDX_W         = 5
) (
  input  logic [IDX_W-1:0]           i_Index,
  input  logic [7:0]                 i_Id,
  input  logic [8*PAYLOAD_BYTES-1:0] i_Payload,
  input  logic [c_CKSUM_W-1:0]       i_Cksum,
  output logic [7:0]                 o_Byte
);

  always_comb begin
    o_Byte = 8'h00;
    if (i_Index == '0) begin
      o_Byte = SYNC_BYTE;
    end else if (i_Index == IDX_W'(1)) begin
      o_Byte = i_Id;
    end else if (i_Index == IDX_W'(PAYLOAD_BYTES + 2)) begin
      o_Byte = i_Cksum;
    end else begin
      for (int k = 0; k < PAYLOAD_BYTES; k++) begin
        if (i_Index == IDX_W'(k + 2)) begin
          o_Byte = i_Payload[8*k +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_framer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_tx_framer                                             |
// | Description : Serialises SYNC/ID/payload/checksum frames into a byte     |
// |               UART transmitter using its DV/Active/Done handshake.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE     = c_SYNC_BYTE_DEFAULT,
  parameter int         ACK_TIMEOUT   = 4
) (
  input  logic                       i_Clock,
  input  logic                       i_Rst_n,
  input  logic                       i_Frame_Valid,
  input  logic [7:0]                 i_Frame_Id,
  input  logic [8*PAYLOAD_BYTES-1:0] i_Frame_Payload,
  output logic                       o_Frame_Ready,
  output logic                       o_Frame_Done,
  output logic                       o_Busy,
  output logic                       o_Tx_DV,
  output logic [7:0]                 o_Tx_Byte,
  input  logic                       i_Tx_Active,
  input  logic                       i_Tx_Done
);

  localparam int               IDX_W    = $clog2(PAYLOAD_BYTES + 3);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES + 2);
  localparam logic [7:0]       TMO_LAST = 8'(ACK_TIMEOUT - 1);

  fr_state_e                  state_q,   state_d;
  logic [7:0]                 id_q,      id_d;
  logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;
  logic [IDX_W-1:0]           idx_q,     idx_d;
  logic [c_CKSUM_W-1:0]       cksum_q,   cksum_d;
  logic [7:0]                 tmo_q,     tmo_d;
  logic                       retry_q,   retry_d;
  logic                       tx_dv_q,   tx_dv_d;
  logic [7:0]                 tx_byte_q, tx_byte_d;
  logic                       done_q,    done_d;
  logic                       busy_q,    busy_d;

  logic       w_tx_rdy;
  logic       w_advance;
  logic [7:0] w_mux_byte;

  frame_byte_mux #(
    .PAYLOAD_BYTES (PAYLOAD_BYTES),
    .SYNC_BYTE     (SYNC_BYTE),
    .IDX_W         (IDX_W)
  ) u_byte_mux (
    .i_Index   (idx_q),
    .i_Id      (id_q),
    .i_Payload (payload_q),
    .i_Cksum   (cksum_q),
    .o_Byte    (w_mux_byte)
  );

  // Done lingers after Active falls, so both must be low before a new DV.
  assign w_tx_rdy = !i_Tx_Active && !i_Tx_Done;

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    payload_d = payload_q;
    idx_d     = idx_q;
    cksum_d   = cksum_q;
    tmo_d     = tmo_q;
    retry_d   = retry_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    w_advance = 1'b0;

    case (state_q)
      s_FR_IDLE: begin
        if (i_Frame_Valid) begin
          id_d      = i_Frame_Id;
          payload_d = i_Frame_Payload;
          cksum_d   = '0;
          idx_d     = '0;
          retry_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = s_FR_ISSUE;
        end
      end
      s_FR_ISSUE: begin
        if (w_tx_rdy) begin
          tx_byte_d = w_mux_byte;
          tx_dv_d   = 1'b1;
          tmo_d     = '0;
          state_d   = s_FR_WAIT_ACK;
          // A re-issued byte was already folded into the checksum.
          if (!retry_q && idx_q != '0 && idx_q != LAST_IDX) begin
            cksum_d = cksum_add(cksum_q, w_mux_byte);
          end
        end
      end
      s_FR_WAIT_ACK: begin
        if (i_Tx_Done) begin
          w_advance = 1'b1;
        end else if (i_Tx_Active) begin
          state_d = s_FR_WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          retry_d = 1'b1;
          state_d = s_FR_ISSUE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      s_FR_WAIT_DONE: begin
        if (i_Tx_Done) begin
          w_advance = 1'b1;
        end
      end
      default: state_d = s_FR_IDLE;
    endcase

    if (w_advance) begin
      retry_d = 1'b0;
      if (idx_q < LAST_IDX) begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = s_FR_ISSUE;
      end else begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = s_FR_IDLE;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= s_FR_IDLE;
      id_q      <= '0;
      payload_q <= '0;
      idx_q     <= '0;
      cksum_q   <= '0;
      tmo_q     <= '0;
      retry_q   <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      payload_q <= payload_d;
      idx_q     <= idx_d;
      cksum_q   <= cksum_d;
      tmo_q     <= tmo_d;
      retry_q   <= retry_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign o_Frame_Ready = (state_q == s_FR_IDLE);
  assign o_Frame_Done  = done_q;
  assign o_Busy        = busy_q;
  assign o_Tx_DV       = tx_dv_q;
  assign o_Tx_Byte     = tx_byte_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Upstream feeder for the byte-serial UART transmitter on the motorboard.
- Accepts one telemetry frame per handshake: an 8-bit ID plus a PAYLOAD_BYTES-wide payload.
- Serialises the frame as SYNC, ID, payload bytes (LSB first), then an 8-bit checksum.
- Hands each byte to the transmitter via its DV/Active/Done interface and never issues a byte the transmitter would drop.

Parameters:
- PAYLOAD_BYTES, 4: payload bytes per frame; legal range 1..16.
- SYNC_BYTE, 8'hAA: first byte of every frame.
- ACK_TIMEOUT, 4: cycles to wait for i_Tx_Active after a DV pulse before re-issuing the same byte; legal range 2..255.

Ports:
- i_Clock  in  1  system clock.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Frame_Valid  in  1  upstream frame request.
- i_Frame_Id  in  8  frame ID.
- i_Frame_Payload  in  8*PAYLOAD_BYTES  payload; byte 0 = bits [7:0].
- o_Frame_Ready  out  1  high when a frame can be accepted.
- o_Frame_Done  out  1  one-cycle pulse after the checksum byte completes.
- o_Busy  out  1  high from frame accept until o_Frame_Done.
- o_Tx_DV  out  1  one-cycle byte-valid pulse to the transmitter.
- o_Tx_Byte  out  8  byte to the transmitter; stable from the DV pulse until Done.
- i_Tx_Active  in  1  transmitter busy.
- i_Tx_Done  in  1  transmitter done; may stay high for 2-3 cycles.

Behaviour:
- Reset values: o_Tx_DV=0, o_Tx_Byte=0, o_Frame_Done=0, o_Busy=0. State=IDLE and all counters=0.
- o_Frame_Ready = (state==IDLE). It is high in the first cycle after reset release.
- Accept: on i_Frame_Valid && o_Frame_Ready:
  - latch ID and payload;
  - clear the checksum accumulator;
  - set byte index=0 and o_Busy=1;
  - go to ISSUE.
- Input changes after accept have no effect.
- Byte sequence by index:
  - index 0 = SYNC_BYTE;
  - index 1 = ID;
  - index 2..PAYLOAD_BYTES+1 = payload byte (index-2);
  - index PAYLOAD_BYTES+2 = checksum.
- Checksum: modulo-256 sum of ID and all payload bytes. SYNC is excluded. Carries out of bit 7 are discarded. The accumulator updates as each byte is issued.
- Transmitter-ready condition: tx_rdy = !i_Tx_Active && !i_Tx_Done. Done stays visible for one cycle after the transmitter returns idle, so DV is never issued while Done is high.
- FSM states:
  - IDLE: wait for accept.
  - ISSUE: when tx_rdy, drive o_Tx_Byte, pulse o_Tx_DV for exactly one cycle, clear the timeout counter, go to WAIT_ACK. Otherwise hold.
  - WAIT_ACK:
    - If i_Tx_Active=1, go to WAIT_DONE.
    - Else increment the timeout counter.
    - At ACK_TIMEOUT, return to ISSUE and re-issue the same byte. The index and checksum do not advance.
  - WAIT_DONE:
    - On i_Tx_Done=1, if index<PAYLOAD_BYTES+2: index++, go to ISSUE.
    - On i_Tx_Done=1 at the last index: pulse o_Frame_Done for 1 cycle, clear o_Busy, go to IDLE.
- Latency: at most 1 cycle from accept to the first DV if the transmitter is idle. Each subsequent DV follows the first cycle where tx_rdy=1 after Done is seen.
- Back-to-back frames: Valid held high during o_Frame_Done is accepted in that same IDLE cycle (Ready is combinational). Its first DV still waits for tx_rdy.
- Valid while busy is ignored; upstream must hold Valid.
- Reset mid-frame: the framer returns to IDLE immediately. The transmitter has no reset and may finish an in-flight byte, so the next frame's first DV waits for tx_rdy. No partial frame resumes.
- Done seen in WAIT_ACK (lost Active edge): treat it as Active followed by Done, i.e. advance as from WAIT_DONE.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants s_FR_IDLE, s_FR_ISSUE, s_FR_WAIT_ACK, s_FR_WAIT_DONE;
  - default SYNC_BYTE;
  - checksum width constant.
- Optional sub-module frame_byte_mux: selects o_Tx_Byte from the latched frame by index. Its combinational mux is isolated from the FSM; everything else stays in one module.

Test Plan:
- ID=0x12, payload=0x11223344, ideal transmitter model (16 clks/bit) -> bytes AA 12 44 33 22 11 BC in order. Exactly 7 DV pulses; one o_Frame_Done; o_Busy drops in the same cycle.
- ID=0xFF, payload=0xFFFFFFFF -> checksum 0xFB (wrap-around); full frame AA FF FF FF FF FF FB.
- Transmitter model holds Done high 3 cycles after each byte -> no DV while Active or Done is high; no byte lost or duplicated.
- Transmitter model ignores the first DV of byte index 2 -> re-issue after 4 cycles with the same byte (0x44). Checksum still 0xBC.
- Valid held continuously with two queued frames -> second accepted in the o_Frame_Done cycle. Frame gap equals only the tx_rdy wait.
- Assert i_Rst_n=0 during payload byte 1, release, then send a new frame -> all outputs reset to 0 and Ready=1. New frame's SYNC DV waits until the in-flight byte's Done clears.
